// File: rtl/edge_detect_mc.sv
// edge_detect_mc
// Multi-channel edge detector for asynchronous or noisy single-bit inputs.
// Each channel goes through a synchroniser chain, then an optional glitch
// filter, then a pulse generator. Pulses set a per-channel sticky flag.
// The OR of all sticky flags drives a registered interrupt.
//
// Parameters
//   CH          number of independent channels (>=1)
//   SYNC_STAGES synchroniser depth per channel (>=2)
//   FILT_CYC    glitch-filter length in clk cycles, 0 = bypass (acts as 1)
//
// Ports
//   clk     single clock, all logic on posedge
//   rstn    asynchronous active-low reset
//   d       raw channel inputs, asynchronous to clk
//   mode    per channel [2i+1:2i]: 00 off, 01 rise, 10 fall, 11 both
//   clr     per-channel sticky clear, level-sensitive, synchronous
//   level   filtered, synchronised level of each channel
//   pulse   one-cycle registered edge pulse
//   sticky  latched event flag per channel
//   irq     registered OR of all sticky bits
module edge_detect_mc #(
  parameter int CH          = 4,
  parameter int SYNC_STAGES = 2,
  parameter int FILT_CYC    = 0
) (
  input  logic            clk,
  input  logic            rstn,
  input  logic [CH-1:0]   d,
  input  logic [2*CH-1:0] mode,
  input  logic [CH-1:0]   clr,
  output logic [CH-1:0]   level,
  output logic [CH-1:0]   pulse,
  output logic [CH-1:0]   sticky,
  output logic            irq
);

  localparam int N  = (FILT_CYC < 1) ? 1 : FILT_CYC;
  localparam int CW = $clog2(N + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(N - 1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);

  logic [CH-1:0] sync;
  logic [CH-1:0] level_nxt;
  logic [CH-1:0] pulse_set;
  logic [CH-1:0] sticky_nxt;

  for (genvar i = 0; i < CH; i++) begin : g_ch
    logic [SYNC_STAGES-1:0] sync_ff;
    logic [CW-1:0]          filt_cnt;
    logic                   flip;

    always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
        sync_ff <= '0;
      end else begin
        sync_ff <= {sync_ff[SYNC_STAGES-2:0], d[i]};
      end
    end

    assign sync[i] = sync_ff[SYNC_STAGES-1];

    // Level follows sync only after N consecutive cycles of disagreement;
    // any agreement in between restarts the count.
    assign flip = (sync[i] != level[i]) && (filt_cnt == CNT_LAST);

    always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
        filt_cnt <= '0;
      end else if ((sync[i] == level[i]) || flip) begin
        filt_cnt <= '0;
      end else begin
        filt_cnt <= filt_cnt + CNT_ONE;
      end
    end

    assign level_nxt[i] = flip ? sync[i] : level[i];
    // sync carries the new level when flip is set: 1 means a rising edge.
    assign pulse_set[i] = flip & (sync[i] ? mode[2*i] : mode[2*i+1]);
  end

  // A new event outranks a clear in the same cycle so nothing is lost.
  always_comb begin
    sticky_nxt = (sticky & ~clr) | pulse_set;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      level  <= '0;
      pulse  <= '0;
      sticky <= '0;
      irq    <= 1'b0;
    end else begin
      level  <= level_nxt;
      pulse  <= pulse_set;
      sticky <= sticky_nxt;
      irq    <= |sticky_nxt;
    end
  end

endmodule

// File: tb/tb_edge_detect_mc.sv
// Testbench for edge_detect_mc: two instances (filter bypassed and
// FILT_CYC=4) share the stimulus. A window-based reference model predicts
// level/pulse/sticky/irq every cycle; directed sequences add fixed checks.
module tb_edge_detect_mc;
  localparam int CH   = 4;
  localparam int SS   = 2;
  localparam int NF0  = 1;
  localparam int NF1  = 4;
  localparam int HMAX = 8192;

  logic            clk = 1'b0;
  logic            rstn;
  logic [CH-1:0]   d;
  logic [2*CH-1:0] mode;
  logic [CH-1:0]   clr;
  logic [CH-1:0]   level0, pulse0, sticky0;
  logic            irq0;
  logic [CH-1:0]   level1, pulse1, sticky1;
  logic            irq1;

  always #5 clk = ~clk;

  edge_detect_mc #(.CH(CH), .SYNC_STAGES(SS), .FILT_CYC(0)) u_dut0 (
    .clk(clk), .rstn(rstn), .d(d), .mode(mode), .clr(clr),
    .level(level0), .pulse(pulse0), .sticky(sticky0), .irq(irq0)
  );

  edge_detect_mc #(.CH(CH), .SYNC_STAGES(SS), .FILT_CYC(4)) u_dut1 (
    .clk(clk), .rstn(rstn), .d(d), .mode(mode), .clr(clr),
    .level(level1), .pulse(pulse1), .sticky(sticky1), .irq(irq1)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Reference model. hist[e-1] holds d as sampled at edge e since reset.
  // The value the filter evaluates at edge t is d captured at edge t-SS.
  // A channel's level flips at edge t when every evaluated value in the
  // last N edges differed from it and none of those edges precede its
  // previous flip.
  logic [CH-1:0] hist [HMAX];
  int            m_edge;
  logic [CH-1:0] m_level  [2];
  logic [CH-1:0] m_pulse  [2];
  logic [CH-1:0] m_sticky [2];
  int            m_last   [2][CH];

  function automatic logic sync_at(input int t, input int ch);
    if (t - SS < 1) return 1'b0;
    return hist[t-SS-1][ch];
  endfunction

  always @(posedge clk or negedge rstn) begin
    int   n;
    logic all_dis;
    if (!rstn) begin
      m_edge = 0;
      for (int u = 0; u < 2; u++) begin
        m_level[u]  = '0;
        m_pulse[u]  = '0;
        m_sticky[u] = '0;
        for (int c = 0; c < CH; c++) m_last[u][c] = 0;
      end
    end else begin
      m_edge = m_edge + 1;
      if (m_edge <= HMAX) hist[m_edge-1] = d;
      for (int u = 0; u < 2; u++) begin
        n = (u == 0) ? NF0 : NF1;
        for (int c = 0; c < CH; c++) begin
          m_pulse[u][c] = 1'b0;
          if (m_edge - n >= m_last[u][c]) begin
            all_dis = 1'b1;
            for (int j = m_edge - n + 1; j <= m_edge; j++)
              if (sync_at(j, c) == m_level[u][c]) all_dis = 1'b0;
            if (all_dis) begin
              m_level[u][c] = ~m_level[u][c];
              m_last[u][c]  = m_edge;
              m_pulse[u][c] = m_level[u][c] ? mode[2*c] : mode[2*c+1];
            end
          end
        end
        m_sticky[u] = (m_sticky[u] & ~clr) | m_pulse[u];
      end
    end
  end

  task automatic compare_all();
    chk("level0",  level0,  m_level[0]);
    chk("pulse0",  pulse0,  m_pulse[0]);
    chk("sticky0", sticky0, m_sticky[0]);
    chk("irq0",    irq0,    |m_sticky[0]);
    chk("level1",  level1,  m_level[1]);
    chk("pulse1",  pulse1,  m_pulse[1]);
    chk("sticky1", sticky1, m_sticky[1]);
    chk("irq1",    irq1,    |m_sticky[1]);
  endtask

  int pc0 [CH];
  int pc1 [CH];

  task automatic clear_counts();
    for (int c = 0; c < CH; c++) begin
      pc0[c] = 0;
      pc1[c] = 0;
    end
  endtask

  task automatic step();
    @(negedge clk);
    compare_all();
    for (int c = 0; c < CH; c++) begin
      pc0[c] += int'(pulse0[c]);
      pc1[c] += int'(pulse1[c]);
    end
  endtask

  task automatic run(input int cycles);
    repeat (cycles) step();
  endtask

  task automatic chk_all_zero(input string tag);
    chk(tag, {level0, pulse0, sticky0, 3'b000, irq0}, 32'h0);
    chk(tag, {level1, pulse1, sticky1, 3'b000, irq1}, 32'h0);
  endtask

  initial begin
    int unsigned r;
    rstn = 1'b0;
    d    = '0;
    mode = {CH{2'b01}};
    clr  = '0;
    clear_counts();
    run(3);
    chk_all_zero("reset_state");
    rstn = 1'b1;
    run(4);

    // Single rise on ch0, bypassed filter: pulse exactly after edge k+2.
    d[0] = 1'b1;
    step(); chk("t1_pulse_k0", pulse0[0], 0);
    step(); chk("t1_pulse_k1", pulse0[0], 0);
    step(); chk("t1_pulse_k2", pulse0[0], 1);
    chk("t1_sticky", sticky0[0], 1);
    chk("t1_irq",    irq0,       1);
    chk("t1_level",  level0[0],  1);
    step(); chk("t1_pulse_k3", pulse0[0], 0);
    chk("t1_sticky_hold", sticky0[0], 1);
    run(6);

    // Clear held through the cycle the fall pulse sets: set wins.
    mode[1:0] = 2'b11;
    clr[0]    = 1'b1;
    d[0]      = 1'b0;
    step(); chk("t2_cleared", sticky0[0], 0);
    step();
    step(); chk("t2_pulse", pulse0[0], 1);
    chk("t2_set_wins", sticky0[0], 1);
    clr = '0;
    step();
    clr = '1;
    step(); chk("t2_clr_sticky", sticky0, 0);
    chk("t2_clr_irq", irq0, 0);
    clr = '0;
    run(8);

    // Per-channel modes: ch1 fall only, ch2 both, ch0 rise, ch3 off.
    mode = {2'b00, 2'b11, 2'b10, 2'b01};
    d[1] = 1'b1; d[2] = 1'b1;
    run(10);
    clear_counts();
    d[1] = 1'b0; d[2] = 1'b0;
    run(5);
    d[1] = 1'b1; d[2] = 1'b1;
    run(10);
    chk("t3_ch1_pulses_n1", pc0[1], 1);
    chk("t3_ch2_pulses_n1", pc0[2], 2);
    chk("t3_ch1_level_n1",  level0[1], 1);
    chk("t3_ch1_pulses_n4", pc1[1], 1);
    chk("t3_ch2_pulses_n4", pc1[2], 2);

    // Glitch filter on the FILT_CYC=4 instance.
    run(8);
    clear_counts();
    d[0] = 1'b1;
    run(3);
    d[0] = 1'b0;
    run(10);
    chk("t4_glitch3_pulses", pc1[0], 0);
    chk("t4_glitch3_level",  level1[0], 0);
    chk("t4_glitch3_n1_pulses", pc0[0], 1);
    clear_counts();
    d[0] = 1'b1;
    run(4);
    d[0] = 1'b0;
    step(); chk("t4_pulse_k4", pulse1[0], 0);
    step(); chk("t4_pulse_k5", pulse1[0], 1);
    chk("t4_level_k5", level1[0], 1);
    step(); chk("t4_pulse_k6", pulse1[0], 0);
    run(10);
    chk("t4_glitch4_pulses", pc1[0], 1);
    chk("t4_level_back", level1[0], 0);

    // Inputs high through reset: every enabled channel reports one rise.
    rstn = 1'b0;
    d    = '1;
    mode = {2'b00, 2'b11, 2'b11, 2'b11};
    step();
    chk_all_zero("t5_in_reset");
    step();
    rstn = 1'b1;
    clear_counts();
    run(12);
    for (int c = 0; c < CH; c++) begin
      chk("t5_pulses_n1", pc0[c], (c == 3) ? 0 : 1);
      chk("t5_pulses_n4", pc1[c], (c == 3) ? 0 : 1);
    end
    chk("t5_level_n1", level0, 4'hF);
    chk("t5_level_n4", level1, 4'hF);

    // Reset while the FILT_CYC=4 counter of ch0 sits at 2.
    d[0] = 1'b0;
    run(4);
    rstn = 1'b0;
    #1;
    chk_all_zero("t6_mid_filter");
    step();
    rstn = 1'b1;
    clear_counts();
    run(12);
    chk("t6_level_n4", level1, 4'b1110);
    chk("t6_ch1_pulses", pc1[1], 1);
    chk("t6_ch3_pulses", pc1[3], 0);

    // Randomised traffic with occasional resets.
    for (int i = 0; i < 3000; i++) begin
      step();
      for (int c = 0; c < CH; c++)
        if ($urandom_range(5) == 0) d[c] = ~d[c];
      if ($urandom_range(19) == 0) begin
        r    = $urandom;
        mode = r[2*CH-1:0];
      end
      for (int c = 0; c < CH; c++)
        clr[c] = ($urandom_range(7) == 0);
      rstn = !(rstn && ($urandom_range(499) == 0));
    end
    rstn = 1'b1;
    run(4);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/edge_detect_mc.md
# edge_detect_mc

Multi-channel, parametrised edge detector for asynchronous or noisy single-bit inputs. Each channel synchronises its input through a configurable flop chain, applies an optional glitch filter, and emits a one-cycle pulse on rising, falling or both edges, selected per channel at run time. Per-channel sticky flags with software clear and an OR-reduced interrupt let a register block or interrupt controller pick up events without polling pulses. It sits at the boundary between pads/foreign clock domains and the synchronous control logic.

## Interface

- CH, 4, number of independent channels (>=1)
- SYNC_STAGES, 2, synchroniser depth per channel (>=2)
- FILT_CYC, 0, glitch-filter length in clk cycles; 0 = filter bypassed (treated as 1)
- clk  input  1  single clock; all logic on posedge
- rstn  input  1  asynchronous, active-low reset
- d  input  CH  raw channel inputs, asynchronous to clk
- mode  input  2*CH  per channel, bits [2i+1:2i]: 00 off, 01 rise, 10 fall, 11 both
- clr  input  CH  per-channel sticky clear, level-sensitive, synchronous to clk
- level  output  CH  filtered, synchronised level of each channel
- pulse  output  CH  one-cycle edge pulse, registered
- sticky  output  CH  latched event flag per channel
- irq  output  1  OR of all sticky bits, registered

## Operation

- Reset (rstn low, asynchronous): all synchroniser flops, level, filter counters, pulse, sticky, irq = 0. Release is synchronous in effect; no pulse generated during reset.
- Synchroniser: d[i] shifts through SYNC_STAGES flops; last stage is sync[i].
- Filter, N = max(FILT_CYC,1), counter width $clog2(N+1):
  - sync[i] == level[i]: counter cleared.
  - sync[i] != level[i] and counter == N-1: level[i] <= sync[i], counter cleared.
  - otherwise counter increments.
  - Disagreement shorter than N consecutive cycles never changes level (glitch rejected).
- Pulse: pulse[i] <= (level[i] changes this edge) AND enabled by mode[i] for that direction (0->1 rise, 1->0 fall). Mode 00 suppresses pulses; level still tracks input.
- mode is sampled every cycle, no synchronisation; a change applies to the edge evaluated at the next clk edge.
- Sticky: sticky[i] <= (sticky[i] & ~clr[i]) | pulse_set[i], where pulse_set is the same-cycle condition loading pulse. Set and clear in the same cycle: set wins (no event lost).
- irq <= |(next sticky); follows sticky with no extra delay.
- A high input at reset release is a rising edge (reset level 0) and is reported if mode enables rise.

## Timing

- d changes, first captured at clk edge k: sync reflects it after edge k+SYNC_STAGES-1; level, pulse, sticky, irq update at edge k+SYNC_STAGES-1+N.
- Default (SYNC_STAGES=2, FILT_CYC=0): pulse high after edge k+2, for exactly one cycle.
- pulse width always 1 cycle; back-to-back edges on a channel are at least N cycles apart at pulse.
- clr asserted before edge e: sticky and irq low after e unless a new pulse is set at e.
- Channels fully independent; simultaneous events on multiple channels all reported in the same cycle.
- Reset asserted mid-filter or mid-pulse: all state cleared immediately; partial counts discarded.

## Test plan

- Defaults, mode=01 all channels; d[0] 0->1 captured at edge 10 -> pulse[0] high only after edge 12, sticky[0]=1, irq=1 from edge 12; level[0]=1.
- mode[1]=10, mode[2]=11, FILT_CYC=0; toggle d[1] and d[2] 1->0->1 with 5-cycle spacing -> ch1 one pulse (fall), ch2 two pulses; ch1 level still follows both edges.
- FILT_CYC=4: 3-cycle high glitch on d[0] -> no pulse, level 0; 4-cycle high -> pulse after edge k+1+4, exactly one cycle.
- clr[0] held high in the same cycle pulse[0] sets -> sticky[0]=1 afterwards; clr[0] next cycle with no pulse -> sticky[0]=0, irq=0 if other sticky bits are 0.
- d all high during reset, mode=11, release rstn -> each channel produces one rise pulse SYNC_STAGES-1+N edges after release; mode=00 channel produces none but level=1.
- Assert rstn low for one cycle while FILT_CYC=4 counter is at 2 -> pulse, sticky, irq, level, counters all 0 immediately; filter restarts from zero after release.
